// File: rtl/mult_seq_pkg.sv
// Shared types and widths for the mult32x32 operand sequencer.
package mult_seq_pkg;

  localparam int OPND_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } mult_seq_state_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } mult_opnd_t;

endpackage

// File: rtl/mult_seq_fifo.sv
// Synchronous operand-pair FIFO with full/empty/count.
// DEPTH must be a power of two so the pointers wrap naturally.
module mult_seq_fifo
  import mult_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  mult_opnd_t                   data_i,
  input  logic                         pop_i,
  output mult_opnd_t                   data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  mult_opnd_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle,
  // which keeps in_ready a pure function of the stored count.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];

  // Storage array is written only on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (doPop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mult_op_sequencer.sv
// Operand queue and start/busy handshake front end for mult32x32.
// Optional running sum of products is built when MULT_SEQ_ACCUM_EN is defined.
module mult_op_sequencer
  import mult_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              mul_start,
  output logic [OPND_W-1:0] mul_a,
  output logic [OPND_W-1:0] mul_b,
`ifdef MULT_SEQ_ACCUM_EN
  input  logic              acc_clear,
  output logic [PROD_W-1:0] acc_sum,
`endif
  input  logic              mul_busy,
  input  logic [PROD_W-1:0] mul_product
);

  mult_seq_state_t               state_q;
  mult_seq_state_t               state_d;
  logic [OPND_W-1:0]             mulA_q;
  logic [OPND_W-1:0]             mulB_q;
  logic                          outValid_q;
  logic [PROD_W-1:0]             outProduct_q;
  logic                          fifoFull;
  logic                          fifoEmpty;
  logic [$clog2(DEPTH+1)-1:0]    fifoCount;
  logic                          fifoPop;
  logic                          mulStart;
  logic                          capture;
  mult_opnd_t                    fifoIn;
  mult_opnd_t                    fifoHead;

  assign fifoIn.a = in_a;
  assign fifoIn.b = in_b;

  mult_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid),
    .data_i  (fifoIn),
    .pop_i   (fifoPop),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign in_ready    = !fifoFull;
  assign out_valid   = outValid_q;
  assign out_product = outProduct_q;
  assign mul_start   = mulStart;
  assign mul_a       = mulA_q;
  assign mul_b       = mulB_q;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: issue only when the output register is free, so a finished
  // product always has somewhere to land; never capture before busy was seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifoEmpty && !outValid_q) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (mul_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!mul_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Per-state outputs: pop on the way into ISSUE, one-cycle start, capture on busy low.
  always_comb begin
    mulStart = 1'b0;
    fifoPop  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE:      fifoPop  = !fifoEmpty && !outValid_q;
      ISSUE:     mulStart = 1'b1;
      WAIT_DONE: capture  = !mul_busy;
      default:   ;
    endcase
  end

  // Operand registers load from the FIFO head at pop and hold through capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mulA_q <= '0;
      mulB_q <= '0;
    end else if (fifoPop) begin
      mulA_q <= fifoHead.a;
      mulB_q <= fifoHead.b;
    end
  end

  // Result register holds the product until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid_q   <= 1'b0;
      outProduct_q <= '0;
    end else if (capture) begin
      outValid_q   <= 1'b1;
      outProduct_q <= mul_product;
    end else if (outValid_q && out_ready) begin
      outValid_q   <= 1'b0;
    end
  end

`ifdef MULT_SEQ_ACCUM_EN
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] acc_d;

  assign acc_sum = acc_q;

  // Running sum wraps modulo 2^64; a clear coinciding with a capture keeps just the new product.
  always_comb begin
    acc_d = acc_q;
    if (capture) begin
      acc_d = acc_clear ? mul_product : acc_q + mul_product;
    end else if (acc_clear) begin
      acc_d = '0;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  // The FIFO's empty flag and its count must always agree.
  assert property (@(posedge clk) disable iff (reset) fifoEmpty == (fifoCount == '0));

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Scoreboard bench for mult_op_sequencer with a behavioural start/busy multiplier.
module tb_mult_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_busy;
  logic [63:0] mul_product;
`ifdef MULT_SEQ_ACCUM_EN
  logic        acc_clear;
  logic [63:0] acc_sum;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  logic [63:0] sbQ [$];

  // Behavioural multiplier: busy low for preDelay cycles after start, high for busyLen.
  int          preDelay = 0;
  int          busyLen = 4;
  int          mTick = 0;
  logic        mActive;
  logic [31:0] mA;
  logic [31:0] mB;
  int          startCount = 0;

  mult_op_sequencer #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
`ifdef MULT_SEQ_ACCUM_EN
    .acc_clear   (acc_clear),
    .acc_sum     (acc_sum),
`endif
    .mul_busy    (mul_busy),
    .mul_product (mul_product)
  );

  always #5 clk = ~clk;

  // Model product is only valid once busy has finished; before that it is junk.
  assign mul_busy    = mActive && (mTick > preDelay) && (mTick <= preDelay + busyLen);
  assign mul_product = (mTick > preDelay + busyLen) ? ({32'b0, mA} * {32'b0, mB})
                                                     : 64'hBADBADBADBADBAD0;

  // Multiplier model timeline, restarted by every start pulse.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mActive <= 1'b0;
      mTick   <= 0;
      mA      <= '0;
      mB      <= '0;
    end else if (mul_start) begin
      mActive    <= 1'b1;
      mTick      <= 1;
      mA         <= mul_a;
      mB         <= mul_b;
      startCount <= startCount + 1;
    end else if (mActive && mTick <= preDelay + busyLen) begin
      mTick <= mTick + 1;
    end else begin
      mActive <= 1'b0;
    end
  end

  // Offer one pair for one cycle; expected product is queued only if accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output bit accepted);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    accepted = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    if (accepted) sbQ.push_back({32'b0, a} * {32'b0, b});
  endtask

  // Wait a bounded number of cycles for a result to appear.
  task automatic waitResult(input int maxCycles, output bit got, output logic [63:0] prod);
    got  = 1'b0;
    prod = '0;
    for (int i = 0; i < maxCycles && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got  = 1'b1;
        prod = out_product;
      end
    end
  endtask

  // Accept the held result for exactly one cycle.
  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Wait a bounded number of cycles for a start pulse.
  task automatic waitStart(input int maxCycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      if (mul_start) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
`ifdef MULT_SEQ_ACCUM_EN
    acc_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    testsRun++; if (out_product !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_out_product got %h want 0", out_product); end
    testsRun++; if (mul_start !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mul_start got %b want 0", mul_start); end
    testsRun++; if ({mul_a, mul_b} !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_mul_ab got %h/%h want 0/0", mul_a, mul_b); end
`ifdef MULT_SEQ_ACCUM_EN
    testsRun++; if (acc_sum !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_acc_sum got %h want 0", acc_sum); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    bit          acc;
    bit          got;
    bit          stable;
    logic [63:0] prod;
    logic [63:0] exp;
    int          s0;
    preDelay = 0;
    busyLen  = 4;
    s0       = startCount;
    applyStimulus(32'd3, 32'd5, acc);
    testsRun++; if (acc !== 1'b1 || mul_start !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_cycle1 accepted %b start %b want 1/0", acc, mul_start); end
    @(negedge clk);
    testsRun++; if (mul_start !== 1'b1 || mul_a !== 32'd3 || mul_b !== 32'd5) begin testsFailed++; $display("[TB] FAIL single_issue start %b a %0d b %0d want 1/3/5", mul_start, mul_a, mul_b); end
    stable = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else if (mul_a !== 32'd3 || mul_b !== 32'd5) stable = 1'b0;
    end
    prod = out_product;
    testsRun++; if (!stable) begin testsFailed++; $display("[TB] FAIL single_operand_hold a %0d b %0d want 3/5", mul_a, mul_b); end
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL single_timeout out_valid %b want 1", out_valid); end
    else begin
      exp = sbQ.pop_front();
      if (prod !== exp) begin testsFailed++; $display("[TB] FAIL single_product got %0d want %0d", prod, exp); end
    end
    testsRun++; if (startCount - s0 != 1) begin testsFailed++; $display("[TB] FAIL single_start_count got %0d want 1", startCount - s0); end
    consume();
  endtask

  task automatic test_max_operands();
    bit          acc;
    bit          got;
    logic [63:0] prod;
    logic [63:0] exp;
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, acc);
    waitResult(40, got, prod);
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL max_timeout out_valid %b want 1", out_valid); end
    else begin
      exp = sbQ.pop_front();
      if (prod !== exp || prod !== 64'hFFFFFFFE00000001) begin testsFailed++; $display("[TB] FAIL max_product got %h want fffffffe00000001", prod); end
    end
    consume();
  endtask

  task automatic test_backpressure();
    bit          acc;
    bit          got;
    logic [63:0] prod;
    logic [63:0] exp;
    int          accepted;
    int          s0;
    out_ready = 1'b0;
    applyStimulus(32'd11, 32'd13, acc);
    waitResult(40, got, prod);
    testsRun++; if (!got) begin testsFailed++; $display("[TB] FAIL bp_first_timeout out_valid %b want 1", out_valid); end
    s0       = startCount;
    accepted = 0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(32'(k), 32'(k + 1), acc);
      if (acc) accepted++;
    end
    testsRun++; if (accepted != 4) begin testsFailed++; $display("[TB] FAIL bp_accepted got %0d want 4", accepted); end
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_in_ready got %b want 0", in_ready); end
    testsRun++; if (startCount != s0 || out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_no_issue starts %0d valid %b want 0/1", startCount - s0, out_valid); end
    for (int i = 0; i < 5; i++) begin
      waitResult(40, got, prod);
      testsRun++;
      if (!got || sbQ.size() == 0) begin testsFailed++; $display("[TB] FAIL bp_drain_timeout item %0d got %b", i, got); end
      else begin
        exp = sbQ.pop_front();
        if (prod !== exp) begin testsFailed++; $display("[TB] FAIL bp_order item %0d got %0d want %0d", i, prod, exp); end
      end
      consume();
      if (sbQ.size() > 0) begin
        testsRun++; if (mul_start !== 1'b0 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_gap start %b valid %b want 0/0", mul_start, out_valid); end
        @(negedge clk);
        testsRun++; if (mul_start !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_issue start %b want 1", mul_start); end
      end
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    testsRun++; if (got || sbQ.size() != 0) begin testsFailed++; $display("[TB] FAIL bp_extra_result valid %b pending %0d want 0/0", got, sbQ.size()); end
  endtask

  task automatic test_reset_mid();
    bit          acc;
    bit          got;
    logic [63:0] prod;
    logic [63:0] exp;
    int          s0;
    preDelay = 0;
    busyLen  = 6;
    applyStimulus(32'd100, 32'd200, acc);
    applyStimulus(32'd300, 32'd400, acc);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mul_busy) got = 1'b1;
    end
    testsRun++; if (!got) begin testsFailed++; $display("[TB] FAIL rst_busy_timeout busy %b want 1", mul_busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    testsRun++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_start !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid valid %b ready %b start %b want 0/1/0", out_valid, in_ready, mul_start); end
    sbQ.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(32'd7, 32'd9, acc);
    waitResult(40, got, prod);
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL rst_fresh_timeout out_valid %b want 1", out_valid); end
    else begin
      exp = sbQ.pop_front();
      if (prod !== exp || prod !== 64'd63) begin testsFailed++; $display("[TB] FAIL rst_fresh_product got %0d want 63", prod); end
    end
    consume();
    s0  = startCount;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    testsRun++; if (got || startCount != s0) begin testsFailed++; $display("[TB] FAIL rst_discard valid %b starts %0d want 0/0", got, startCount - s0); end
  endtask

  task automatic test_busy_protocol();
    bit          acc;
    bit          got;
    logic [63:0] prod;
    logic [63:0] exp;
    int          lat;
    preDelay = 3;
    busyLen  = 5;
    applyStimulus(32'd6, 32'd7, acc);
    waitStart(10, got);
    testsRun++; if (!got) begin testsFailed++; $display("[TB] FAIL busy_start_timeout start %b want 1", mul_start); end
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; lat = i; end
    end
    prod = out_product;
    testsRun++; if (lat != 10) begin testsFailed++; $display("[TB] FAIL busy_latency got %0d want 10", lat); end
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL busy_timeout out_valid %b want 1", out_valid); end
    else begin
      exp = sbQ.pop_front();
      if (prod !== exp) begin testsFailed++; $display("[TB] FAIL busy_product got %h want %h", prod, exp); end
    end
    consume();
  endtask

`ifdef MULT_SEQ_ACCUM_EN
  task automatic test_accum();
    bit          acc;
    bit          got;
    logic [63:0] prod;
    logic [63:0] exp;
    preDelay  = 0;
    busyLen   = 2;
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    testsRun++; if (acc_sum !== 64'h0) begin testsFailed++; $display("[TB] FAIL acc_clear got %h want 0", acc_sum); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, acc);
      waitResult(40, got, prod);
      testsRun++;
      if (!got) begin testsFailed++; $display("[TB] FAIL acc_max_timeout item %0d", i); end
      else begin
        exp = sbQ.pop_front();
        if (prod !== exp) begin testsFailed++; $display("[TB] FAIL acc_max_product got %h want %h", prod, exp); end
      end
      consume();
    end
    testsRun++; if (acc_sum !== 64'hFFFFFFFC00000002) begin testsFailed++; $display("[TB] FAIL acc_wrap got %h want fffffffc00000002", acc_sum); end
    applyStimulus(32'd3, 32'd5, acc);
    waitStart(10, got);
    repeat (3) @(negedge clk);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    testsRun++; if (out_valid !== 1'b1 || acc_sum !== 64'd15) begin testsFailed++; $display("[TB] FAIL acc_clear_capture valid %b sum %h want 1/15", out_valid, acc_sum); end
    if (sbQ.size() > 0) exp = sbQ.pop_front();
    consume();
  endtask
`endif

  // Test sequence.
  initial begin
    test_reset();
    test_single_op();
    test_max_operands();
    test_backpressure();
    test_reset_mid();
    test_busy_protocol();
`ifdef MULT_SEQ_ACCUM_EN
    test_accum();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
